// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_unit : PC / IR owner and instruction-memory read sequencer      |
// |              for the accumulator CPU controller.                      |
// | Revision   : 1.0                                                      |
// +----------------------------------------------------------------------+
module fetch_unit #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 8,
  parameter int IMEM_LAT = 1,
  parameter int RST_PC   = 0,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_load,
  input  logic              pc_en,
  input  logic              jmp,
  input  logic              halt,
  input  logic              memIns_en,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              imem_rd,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [2:0]        opcode,
  output logic [ADDR_W-1:0] operand_addr,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic [CNT_W-1:0]  instr_count
);

  localparam logic [ADDR_W-1:0] c_rst_pc  = ADDR_W'(RST_PC);
  localparam logic [CNT_W-1:0]  c_cnt_max = '1;

  logic [ADDR_W-1:0]   r_pc;
  logic [DATA_W-1:0]   r_ir;
  logic                r_ir_valid;
  logic                r_halted;
  logic [CNT_W-1:0]    r_cnt;
  logic [IMEM_LAT-1:0] r_pipe;
  logic                w_issue;
  logic                w_capture;

  assign w_issue   = memIns_en & ~r_halted & ~rst;
  // A capture landing on the halting edge is discarded along with the flush.
  assign w_capture = r_pipe[IMEM_LAT-1] & ~halt;

  generate
    if (IMEM_LAT == 1) begin : g_pipe_single
      always_ff @(posedge clk or posedge rst) begin
        if (rst)       r_pipe <= '0;
        else if (halt) r_pipe <= '0;
        else           r_pipe <= w_issue;
      end
    end else begin : g_pipe_shift
      always_ff @(posedge clk or posedge rst) begin
        if (rst)       r_pipe <= '0;
        else if (halt) r_pipe <= '0;
        else           r_pipe <= {r_pipe[IMEM_LAT-2:0], w_issue};
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc       <= c_rst_pc;
      r_ir       <= '0;
      r_ir_valid <= 1'b0;
      r_halted   <= 1'b0;
      r_cnt      <= '0;
    end else if (!r_halted) begin
      if (halt) r_halted <= 1'b1;

      if (pc_load && jmp)
        r_pc <= r_ir[ADDR_W-1:0];
      else if (pc_load || pc_en)
        r_pc <= r_pc + ADDR_W'(1);

      if (w_capture) begin
        r_ir       <= imem_rdata;
        r_ir_valid <= 1'b1;
        if (r_cnt != c_cnt_max) r_cnt <= r_cnt + CNT_W'(1);
      end else if (r_pipe[0]) begin
        r_ir_valid <= 1'b0;
      end
    end
  end

  assign imem_rd      = w_issue;
  assign imem_addr    = r_pc;
  assign opcode       = r_ir[DATA_W-1 -: 3];
  assign operand_addr = r_ir[ADDR_W-1:0];
  assign ir_valid     = r_ir_valid;
  assign pc           = r_pc;
  assign halted       = r_halted;
  assign instr_count  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fetch_unit : directed scoreboard bench, one fetch_unit with a      |
// |                 1-cycle memory and one with a 2-cycle memory.         |
// | Revision      : 1.0                                                   |
// +----------------------------------------------------------------------+
module tb_fetch_unit;
  localparam int AW = 5;
  localparam int DW = 8;
  localparam int CW = 16;

  typedef struct {
    logic [DW-1:0] word;
    int            due;
    int            cnt;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] mem [32];

  // Instance A: IMEM_LAT = 1
  logic          rst_a = 1'b1, a_load = 1'b0, a_en = 1'b0, a_jmp = 1'b0, a_halt = 1'b0, a_mem_en = 1'b0;
  logic [DW-1:0] a_rdata;
  logic          a_rd, a_valid, a_halted;
  logic [AW-1:0] a_addr, a_opnd, a_pc;
  logic [2:0]    a_op;
  logic [CW-1:0] a_cnt;

  // Instance B: IMEM_LAT = 2
  logic          rst_b = 1'b1, b_load = 1'b0, b_en = 1'b0, b_jmp = 1'b0, b_halt = 1'b0, b_mem_en = 1'b0;
  logic [DW-1:0] b_rdata;
  logic          b_rd, b_valid, b_halted;
  logic [AW-1:0] b_addr, b_opnd, b_pc;
  logic [2:0]    b_op;
  logic [CW-1:0] b_cnt;

  fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .IMEM_LAT(1), .RST_PC(0), .CNT_W(CW)) u_a (
    .clk(clk), .rst(rst_a), .pc_load(a_load), .pc_en(a_en), .jmp(a_jmp), .halt(a_halt),
    .memIns_en(a_mem_en), .imem_rdata(a_rdata), .imem_rd(a_rd), .imem_addr(a_addr),
    .opcode(a_op), .operand_addr(a_opnd), .ir_valid(a_valid), .pc(a_pc),
    .halted(a_halted), .instr_count(a_cnt));

  fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .IMEM_LAT(2), .RST_PC(0), .CNT_W(CW)) u_b (
    .clk(clk), .rst(rst_b), .pc_load(b_load), .pc_en(b_en), .jmp(b_jmp), .halt(b_halt),
    .memIns_en(b_mem_en), .imem_rdata(b_rdata), .imem_rd(b_rd), .imem_addr(b_addr),
    .opcode(b_op), .operand_addr(b_opnd), .ir_valid(b_valid), .pc(b_pc),
    .halted(b_halted), .instr_count(b_cnt));

  // Synchronous memories; idle cycles return zero.
  logic [DW-1:0] a_d = '0, b_d0 = '0, b_d1 = '0;
  always @(posedge clk) begin
    a_d  <= a_rd ? mem[a_addr] : '0;
    b_d0 <= b_rd ? mem[b_addr] : '0;
    b_d1 <= b_d0;
  end
  assign a_rdata = a_d;
  assign b_rdata = b_d1;

  exp_t qa[$];
  exp_t qb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitors: a rise in instr_count marks a capture, compared against the queue head.
  logic [CW-1:0] a_prev = '0, b_prev = '0;
  exp_t ea, eb;
  always @(negedge clk) begin
    if (!rst_a && a_cnt !== a_prev && a_cnt !== '0) begin
      if (qa.size() == 0) begin
        total++; bad++;
        $display("FAIL a_unexpected_capture: got count=%0h expected no capture", a_cnt);
      end else begin
        ea = qa.pop_front();
        check("a_sb_opcode", 32'(a_op), 32'(ea.word[7:5]));
        check("a_sb_operand", 32'(a_opnd), 32'(ea.word[4:0]));
        check("a_sb_count", 32'(a_cnt), 32'(ea.cnt));
        check("a_sb_valid", 32'(a_valid), 32'd1);
        check("a_sb_cycle", 32'(cyc), 32'(ea.due));
      end
    end
    a_prev = a_cnt;
  end
  always @(negedge clk) begin
    if (!rst_b && b_cnt !== b_prev && b_cnt !== '0) begin
      if (qb.size() == 0) begin
        total++; bad++;
        $display("FAIL b_unexpected_capture: got count=%0h expected no capture", b_cnt);
      end else begin
        eb = qb.pop_front();
        check("b_sb_opcode", 32'(b_op), 32'(eb.word[7:5]));
        check("b_sb_operand", 32'(b_opnd), 32'(eb.word[4:0]));
        check("b_sb_count", 32'(b_cnt), 32'(eb.cnt));
        check("b_sb_valid", 32'(b_valid), 32'd1);
        check("b_sb_cycle", 32'(cyc), 32'(eb.due));
      end
    end
    b_prev = b_cnt;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_a(input int addr, input int cnt);
    exp_t t;
    a_mem_en = 1'b1;
    #1;
    check("a_fetch_addr", 32'(a_addr), 32'(addr));
    check("a_fetch_rd", 32'(a_rd), 32'd1);
    t.word = mem[addr]; t.due = cyc + 2; t.cnt = cnt;
    qa.push_back(t);
    tick();
    a_mem_en = 1'b0;
    tick();
  endtask

  task automatic fetch_b(input int addr, input int cnt);
    exp_t t;
    b_mem_en = 1'b1;
    #1;
    check("b_fetch_addr", 32'(b_addr), 32'(addr));
    t.word = mem[addr]; t.due = cyc + 3; t.cnt = cnt;
    qb.push_back(t);
    tick();
    b_mem_en = 1'b0;
    tick();
    check("b_valid_clear", 32'(b_valid), 32'd0);
    tick();
  endtask

  task automatic pulse_a(input logic ld, input logic jp, input logic en);
    a_load = ld; a_jmp = jp; a_en = en;
    tick();
    a_load = 1'b0; a_jmp = 1'b0; a_en = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    mem[0] = 8'hA3; mem[1] = 8'hE9; mem[2] = 8'h31; mem[6] = 8'hFF; mem[10] = 8'h24;

    a_mem_en = 1'b1;
    #12;
    check("rst_pc", 32'(a_pc), 32'd0);
    check("rst_opcode", 32'(a_op), 32'd0);
    check("rst_operand", 32'(a_opnd), 32'd0);
    check("rst_valid", 32'(a_valid), 32'd0);
    check("rst_halted", 32'(a_halted), 32'd0);
    check("rst_count", 32'(a_cnt), 32'd0);
    check("rst_rd_gated", 32'(a_rd), 32'd0);
    a_mem_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    tick();

    // First fetch, LAT=1
    fetch_a(0, 1);
    check("fetch_opcode", 32'(a_op), 32'h5);
    check("fetch_operand", 32'(a_opnd), 32'h03);
    check("fetch_count", 32'(a_cnt), 32'd1);

    // Jump to 9, then increment
    pulse_a(1'b0, 1'b0, 1'b1);
    check("inc_pc1", 32'(a_pc), 32'd1);
    fetch_a(1, 2);
    pulse_a(1'b1, 1'b1, 1'b0);
    check("jump_pc9", 32'(a_pc), 32'd9);
    pulse_a(1'b0, 1'b0, 1'b1);
    check("inc_pc10", 32'(a_pc), 32'd10);

    // Skip beats increment
    fetch_a(10, 3);
    pulse_a(1'b1, 1'b1, 1'b0);
    check("jump_pc4", 32'(a_pc), 32'd4);
    pulse_a(1'b1, 1'b0, 1'b1);
    check("skip_priority_pc5", 32'(a_pc), 32'd5);
    pulse_a(1'b0, 1'b0, 1'b1);
    check("inc_pc6", 32'(a_pc), 32'd6);

    // Wrap via increment and via skip
    fetch_a(6, 4);
    pulse_a(1'b1, 1'b1, 1'b0);
    check("jump_pc31", 32'(a_pc), 32'd31);
    pulse_a(1'b0, 1'b0, 1'b1);
    check("wrap_inc", 32'(a_pc), 32'd0);
    pulse_a(1'b1, 1'b1, 1'b0);
    pulse_a(1'b1, 1'b0, 1'b0);
    check("wrap_skip", 32'(a_pc), 32'd0);

    // Back-to-back reads while incrementing
    begin
      exp_t t;
      a_mem_en = 1'b1; a_en = 1'b1;
      #1;
      t.word = mem[0]; t.due = cyc + 2; t.cnt = 5;
      qa.push_back(t);
      tick();
      check("b2b_addr2", 32'(a_addr), 32'd1);
      t.word = mem[1]; t.due = cyc + 2; t.cnt = 6;
      qa.push_back(t);
      tick();
      a_mem_en = 1'b0; a_en = 1'b0;
      tick();
      check("b2b_opcode", 32'(a_op), 32'h7);
      check("b2b_count", 32'(a_cnt), 32'd6);
    end

    // Async reset with pc=17, ir_valid=1
    fetch_a(2, 7);
    pulse_a(1'b1, 1'b1, 1'b0);
    check("pre_rst_pc17", 32'(a_pc), 32'd17);
    check("pre_rst_valid", 32'(a_valid), 32'd1);
    #2 rst_a = 1'b1;
    #1;
    check("arst_pc", 32'(a_pc), 32'd0);
    check("arst_valid", 32'(a_valid), 32'd0);
    check("arst_halted", 32'(a_halted), 32'd0);
    check("arst_count", 32'(a_cnt), 32'd0);
    check("arst_opcode", 32'(a_op), 32'd0);
    @(negedge clk);
    rst_a = 1'b0;
    tick();

    // Reset between issue and capture loses the read
    a_mem_en = 1'b1;
    tick();
    a_mem_en = 1'b0;
    #2 rst_a = 1'b1;
    #2 rst_a = 1'b0;
    tick();
    tick();
    check("midrd_count", 32'(a_cnt), 32'd0);
    check("midrd_valid", 32'(a_valid), 32'd0);

    // LAT=2 fetches, then halt with a read in flight
    fetch_b(0, 1);
    b_en = 1'b1; tick(); b_en = 1'b0;
    fetch_b(1, 2);
    b_en = 1'b1; tick(); b_en = 1'b0;
    check("b_pc2", 32'(b_pc), 32'd2);
    b_mem_en = 1'b1;
    #1;
    check("b_halt_rd_addr", 32'(b_addr), 32'd2);
    tick();
    b_halt = 1'b1; b_en = 1'b1;
    tick();
    b_halt = 1'b0; b_en = 1'b0;
    check("halt_set", 32'(b_halted), 32'd1);
    check("halt_rd_gated", 32'(b_rd), 32'd0);
    check("halt_edge_pc", 32'(b_pc), 32'd3);
    for (int i = 0; i < 10; i++) begin
      b_en = 1'b1; tick();
      b_en = 1'b0; tick();
    end
    check("halt_pc_hold", 32'(b_pc), 32'd3);
    check("halt_count_hold", 32'(b_cnt), 32'd2);
    check("halt_opcode_hold", 32'(b_op), 32'h7);
    check("halt_operand_hold", 32'(b_opnd), 32'h09);
    check("halt_sticky", 32'(b_halted), 32'd1);
    check("halt_rd_still0", 32'(b_rd), 32'd0);
    b_mem_en = 1'b0;

    repeat (3) tick();
    check("a_queue_drained", 32'(qa.size()), 32'd0);
    check("b_queue_drained", 32'(qb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
